// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner: per-frame snapshot of the BCD
// digits, guard-then-show scan per digit, leading-zero blanking, registered pins.
module seven_seg_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] dig4,
  input  logic [3:0] dp_in,
  input  logic       blank_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int MAXC = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {GUARD = 1'b0, SHOW = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [1:0]       idx_r, idx_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [3:0][3:0]  snap_dig_r;
  logic [3:0]       snap_dp_r;
  logic             snap_blank_r;
  logic             snap_load_s;
  logic             blank2_s, blank3_s, blank4_s, blank_cur_s;
  logic [3:0]       digit_s;
  logic [3:0]       an_s;
  logic [6:0]       seg_s;
  logic             dp_s;

  // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Scan state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= GUARD;
      idx_r   <= 2'd0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state: dark guard interval, then the lit dwell, then advance digit.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    case (state_r)
      GUARD: begin
        if (cnt_r == CW'(GUARD_CYC - 1)) begin
          state_s = SHOW;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end
      SHOW: begin
        if (cnt_r == CW'(SCAN_DIV - 1)) begin
          state_s = GUARD;
          cnt_s   = {CW{1'b0}};
          idx_s   = idx_r + 2'd1;
        end else begin
          cnt_s = cnt_r + CW'(1'b1);
        end
      end
      default: begin
        state_s = GUARD;
        idx_s   = 2'd0;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  assign snap_load_s = (state_r == GUARD) && (idx_r == 2'd0) && (cnt_r == {CW{1'b0}});

  // Frame snapshot, taken once at the start of each frame to avoid torn digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_dig_r   <= 16'h0000;
      snap_dp_r    <= 4'b0000;
      snap_blank_r <= 1'b0;
    end else if (snap_load_s) begin
      snap_dig_r   <= {dig4, dig3, dig2, dig1};
      snap_dp_r    <= dp_in;
      snap_blank_r <= blank_en;
    end
  end

  assign blank4_s = snap_blank_r && (snap_dig_r[3] == 4'd0);
  assign blank3_s = blank4_s && (snap_dig_r[2] == 4'd0);
  assign blank2_s = blank3_s && (snap_dig_r[1] == 4'd0);
  assign digit_s  = snap_dig_r[idx_r];

  // Pin values for the current state; everything dark outside SHOW.
  always_comb begin
    an_s        = 4'b1111;
    seg_s       = 7'b1111111;
    dp_s        = 1'b1;
    blank_cur_s = 1'b0;
    case (idx_r)
      2'd1:    blank_cur_s = blank2_s;
      2'd2:    blank_cur_s = blank3_s;
      2'd3:    blank_cur_s = blank4_s;
      default: blank_cur_s = 1'b0;
    endcase
    if (state_r == SHOW) begin
      an_s  = ~(4'b0001 << idx_r);
      seg_s = blank_cur_s ? 7'b1111111 : seg_decode(digit_s);
      dp_s  = ~snap_dp_r[idx_r];
    end else begin
      an_s  = 4'b1111;
      seg_s = 7'b1111111;
      dp_s  = 1'b1;
    end
  end

  // Registered pins; reset darkens them without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_s;
      seg <= seg_s;
      dp  <= dp_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: stimulus queues expected lit windows,
// a negedge monitor pops and checks them plus scan-timing invariants.
module tb_seven_seg_scan;

  localparam int SD = 4;
  localparam int GC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dig1, dig2, dig3, dig4, dp_in;
  logic       blank_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } win_t;

  win_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   sb_on    = 1'b1;

  seven_seg_scan #(.SCAN_DIV(SD), .GUARD_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .dp_in(dp_in), .blank_en(blank_en), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pw(input logic [3:0] a, input logic [6:0] s, input logic d);
    win_t w;
    w.an = a; w.seg = s; w.dp = d;
    q.push_back(w);
  endtask

  // One frame of expected windows, digit 1 first; dpo[i] is the DP pin in window i.
  task automatic pf(input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                    input logic [6:0] s4, input logic [3:0] dpo);
    pw(4'b1110, s1, dpo[0]);
    pw(4'b1101, s2, dpo[1]);
    pw(4'b1011, s3, dpo[2]);
    pw(4'b0111, s4, dpo[3]);
  endtask

  // Called just after a rising edge; reset must darken the pins at once.
  task automatic do_reset(input logic [3:0] d4, input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] dpi, input logic bl);
    rst_n = 1'b0;
    #1;
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'h1);
    dig4 = d4; dig3 = d3; dig2 = d2; dig1 = d1; dp_in = dpi; blank_en = bl;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: window/guard timing, anti-ghosting, and scoreboard compare.
  bit         in_win   = 1'b0;
  bit         have_prev = 1'b0;
  bit         have_exp = 1'b0;
  int         win_len  = 0;
  int         dark_len = 0;
  logic [3:0] win_an;
  win_t       exp_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_win = 1'b0; have_prev = 1'b0; have_exp = 1'b0; dark_len = 0;
    end else if (an == 4'b1111) begin
      chk("dark_seg", 32'(seg), 32'h7F);
      chk("dark_dp", 32'(dp), 32'h1);
      if (in_win) begin
        chk("lit_len", 32'(win_len), 32'(SD));
        in_win = 1'b0; have_prev = 1'b1; dark_len = 0;
      end
      dark_len++;
    end else begin
      chk("one_low", 32'($countones(~an)), 32'd1);
      if (!in_win) begin
        if (have_prev) chk("guard_len", 32'(dark_len), 32'(GC));
        in_win = 1'b1; win_len = 0; win_an = an; have_exp = 1'b0;
        if (sb_on) begin
          if (q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_unexpected: got window an=%b expected none", an);
          end else begin
            exp_w = q.pop_front();
            have_exp = 1'b1;
          end
        end
      end else begin
        chk("no_ghost", 32'(an), 32'(win_an));
      end
      win_len++;
      if (have_exp) begin
        chk("sb_an", 32'(an), 32'(exp_w.an));
        chk("sb_seg", 32'(seg), 32'(exp_w.seg));
        chk("sb_dp", 32'(dp), 32'(exp_w.dp));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    dig1 = 4'd0; dig2 = 4'd0; dig3 = 4'd0; dig4 = 4'd0; dp_in = 4'd0; blank_en = 1'b0;
    @(posedge clk); #1;

    // Plain 1,2,3,4 scan, two frames.
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    pf(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111);
    pf(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111);
    repeat (50) @(posedge clk); #1;

    // All zero with blanking: only digit 1 lights.
    do_reset(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
    pf(7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111, 4'b1111);
    repeat (26) @(posedge clk); #1;

    // 0,1,0,0 with blanking: only digit 4 blank.
    do_reset(4'd0, 4'd1, 4'd0, 4'd0, 4'b0000, 1'b1);
    pf(7'b1000000, 7'b1000000, 7'b1111001, 7'b1111111, 4'b1111);
    repeat (26) @(posedge clk); #1;

    // DIG1 4->7 during digit-2 window: visible only from next frame.
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    pf(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111);
    pf(7'b1111000, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111);
    repeat (10) @(posedge clk); #1;
    dig1 = 4'd7;
    repeat (40) @(posedge clk); #1;

    // Non-BCD dash with decimal point on digit 1.
    do_reset(4'd0, 4'd0, 4'd0, 4'hC, 4'b0001, 1'b0);
    pf(7'b0111111, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1110);
    repeat (26) @(posedge clk); #1;

    // Reset in the middle of the digit-3 window, then restart at digit 1.
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    pw(4'b1110, 7'b0011001, 1'b1);
    pw(4'b1101, 7'b0110000, 1'b1);
    pw(4'b1011, 7'b0100100, 1'b1);
    repeat (16) @(posedge clk); #1;
    chk("mid_digit3_lit", 32'(an), 32'hB);
    do_reset(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    pf(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 4'b1111);
    repeat (2) @(posedge clk); #1;
    chk("restart_guard", 32'(an), 32'hF);
    @(posedge clk); #1;
    chk("restart_digit1", 32'(an), 32'hE);
    repeat (23) @(posedge clk); #1;
    chk("sb_drain", 32'(q.size()), 32'd0);

    // Random inputs over 1000 frames: timing and anti-ghost invariants only.
    sb_on = 1'b0;
    do_reset(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0);
    repeat (1000 * 4 * (SD + GC)) begin
      @(posedge clk); #1;
      dig1 = 4'($urandom); dig2 = 4'($urandom); dig3 = 4'($urandom); dig4 = 4'($urandom);
      dp_in = 4'($urandom); blank_en = 1'($urandom);
    end
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
